// File: rtl/cfu_simd_pkg.sv
// ============================================================================
// Module  : cfu_simd_pkg
// Brief   : Opcodes, FSM states and width helpers shared by the SIMD MAC CFU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cfu_simd_pkg;

  localparam logic [6:0] OP_CLR_ACC    = 7'd0;
  localparam logic [6:0] OP_SET_OFFSET = 7'd1;
  localparam logic [6:0] OP_MAC        = 7'd2;
  localparam logic [6:0] OP_READ_ACC   = 7'd3;
  localparam logic [6:0] OP_READ_CLR   = 7'd4;
  localparam logic [6:0] OP_LOAD_ACC   = 7'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] RSP_UNKNOWN = 32'hFFFF_FFFF;

  function automatic int lanes_of(input int data_w);
    return 32 / data_w;
  endfunction

  // Exact width of the lane sum: offset-add grows one bit, the multiply adds
  // DATA_W bits, and the add tree adds log2(LANES) bits.
  function automatic int dot_sum_width(input int data_w, input int offset_w);
    int add_w;
    add_w = ((data_w > offset_w) ? data_w : offset_w) + 1;
    return add_w + data_w + $clog2(32 / data_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_simd_dot.sv
// ============================================================================
// Module  : cfu_simd_dot
// Brief   : LANES-wide sum of (a_i + offset) * b_i with STAGES register stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cfu_simd_dot
  import cfu_simd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 9,
  parameter int STAGES   = 1,
  parameter int SUM_W    = dot_sum_width(DATA_W, OFFSET_W)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                a,
  input  logic [31:0]                b,
  input  logic signed [OFFSET_W-1:0] offset,
  output logic signed [SUM_W-1:0]    sum
);

  localparam int LANES  = lanes_of(DATA_W);
  localparam int ADD_W  = ((DATA_W > OFFSET_W) ? DATA_W : OFFSET_W) + 1;
  localparam int PROD_W = ADD_W + DATA_W;

  logic signed [PROD_W-1:0] w_prod [LANES];
  logic signed [PROD_W-1:0] w_src  [LANES];
  logic signed [SUM_W-1:0]  w_tree;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ADD_W-1:0] w_a_off;
    assign w_a_off   = ADD_W'($signed(a[i*DATA_W +: DATA_W])) + ADD_W'(offset);
    assign w_prod[i] = PROD_W'(w_a_off) * PROD_W'($signed(b[i*DATA_W +: DATA_W]));
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) begin
      w_tree = w_tree + SUM_W'(w_src[i]);
    end
  end

  if (STAGES == 0) begin : g_comb
    always_comb begin
      for (int i = 0; i < LANES; i++) w_src[i] = w_prod[i];
    end
    assign sum = w_tree;
  end else begin : g_pipe
    // First stage sits after the multipliers; later stages only carry the sum.
    logic signed [PROD_W-1:0] r_prod [LANES];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
      end
    end

    always_comb begin
      for (int i = 0; i < LANES; i++) w_src[i] = r_prod[i];
    end

    if (STAGES == 1) begin : g_direct
      assign sum = w_tree;
    end else begin : g_delay
      logic signed [SUM_W-1:0] r_dly [STAGES-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < STAGES - 1; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_tree;
          for (int i = 1; i < STAGES - 1; i++) r_dly[i] <= r_dly[i-1];
        end
      end

      assign sum = r_dly[STAGES-2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfu_simd_mac.sv
// ============================================================================
// Module  : cfu_simd_mac
// Brief   : CFU front-end with packed SIMD offset-MAC into a wide accumulator.
//           Define CFU_SIMD_SAT_EN to saturate read-back values to int32.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cfu_simd_mac
  import cfu_simd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OFFSET_W    = 9,
  parameter int ACC_W       = 40,
  parameter int MAC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int SUM_W = dot_sum_width(DATA_W, OFFSET_W);
  localparam int EXT_W = (SUM_W > ACC_W) ? SUM_W : ACC_W;

  state_t                     r_state;
  logic [ACC_W-1:0]           r_acc;
  logic signed [OFFSET_W-1:0] r_offset;
  logic [1:0]                 r_cnt;
  logic [31:0]                r_rsp;

  logic [6:0]                 w_opcode;
  logic                       w_accept;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [EXT_W-1:0]    w_sum_ext;
  logic [ACC_W-1:0]           w_mac_acc;
  logic [63:0]                w_load;
  logic                       w_unused;

  assign w_opcode  = cmd_payload_function_id[9:3];
  assign w_unused  = ^cmd_payload_function_id[2:0];
  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_sum_ext = EXT_W'(w_sum);
  assign w_mac_acc = r_acc + w_sum_ext[ACC_W-1:0];
  assign w_load    = {cmd_payload_inputs_1, cmd_payload_inputs_0};

  assign cmd_ready             = (r_state == ST_IDLE);
  assign rsp_valid             = (r_state == ST_RESP);
  assign rsp_payload_outputs_0 = r_rsp;

  cfu_simd_dot #(
    .DATA_W   (DATA_W),
    .OFFSET_W (OFFSET_W),
    .STAGES   (MAC_LATENCY - 1),
    .SUM_W    (SUM_W)
  ) u_dot (
    .clk    (clk),
    .reset  (reset),
    .a      (cmd_payload_inputs_0),
    .b      (cmd_payload_inputs_1),
    .offset (r_offset),
    .sum    (w_sum)
  );

  function automatic logic [31:0] read_value(input logic [ACC_W-1:0] acc);
`ifdef CFU_SIMD_SAT_EN
    if ((acc[ACC_W-1:31] == '0) || (acc[ACC_W-1:31] == '1)) return acc[31:0];
    else if (acc[ACC_W-1])                                   return 32'h8000_0000;
    else                                                     return 32'h7FFF_FFFF;
`else
    return acc[31:0];
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_offset <= '0;
      r_cnt    <= '0;
      r_rsp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RESP;
            case (w_opcode)
              OP_CLR_ACC: begin
                r_acc <= '0;
                r_rsp <= '0;
              end
              OP_SET_OFFSET: begin
                r_offset <= $signed(cmd_payload_inputs_0[OFFSET_W-1:0]);
                r_rsp    <= '0;
              end
              OP_MAC: begin
                // A single-cycle MAC folds straight into the accumulator.
                if (MAC_LATENCY == 1) begin
                  r_acc <= w_mac_acc;
                  r_rsp <= read_value(w_mac_acc);
                end else begin
                  r_cnt   <= 2'(MAC_LATENCY - 2);
                  r_state <= ST_EXEC;
                end
              end
              OP_READ_ACC: r_rsp <= read_value(r_acc);
              OP_READ_CLR: begin
                r_rsp <= read_value(r_acc);
                r_acc <= '0;
              end
              OP_LOAD_ACC: begin
                r_acc <= w_load[ACC_W-1:0];
                r_rsp <= '0;
              end
              default: r_rsp <= RSP_UNKNOWN;
            endcase
          end
        end
        ST_EXEC: begin
          if (r_cnt == 2'd0) begin
            r_acc   <= w_mac_acc;
            r_rsp   <= read_value(w_mac_acc);
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfu_simd_mac.sv
// ============================================================================
// Module  : tb_cfu_simd_mac
// Brief   : Directed self-checking bench for cfu_simd_mac (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfu_simd_mac;

  localparam logic [6:0] OP_CLR  = 7'd0;
  localparam logic [6:0] OP_OFS  = 7'd1;
  localparam logic [6:0] OP_MAC  = 7'd2;
  localparam logic [6:0] OP_READ = 7'd3;
  localparam logic [6:0] OP_RCLR = 7'd4;
  localparam logic [6:0] OP_LOAD = 7'd5;
  localparam int         MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  function_id = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] data;
  int          lat;
  logic        busy_ok;
  logic [31:0] exp_sat;

  cfu_simd_mac #(
    .DATA_W(8), .OFFSET_W(9), .ACC_W(40), .MAC_LATENCY(MAC_LAT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (function_id),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Issue one command, wait for its response, and complete the handshake.
  task automatic send(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] rdata, output int rlat, output logic rbusy);
    int n;
    @(negedge clk);
    cmd_valid   = 1'b1;
    function_id = {op, 3'b000};
    in0 = a;
    in1 = b;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in0 = 32'hDEAD_BEEF;
    in1 = 32'hDEAD_BEEF;
    rbusy = 1'b1;
    rlat  = 1;
    while (!rsp_valid && rlat < 20) begin
      if (cmd_ready) rbusy = 1'b0;
      @(posedge clk); #1;
      rlat++;
    end
    if (cmd_ready) rbusy = 1'b0;
    rdata = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_payload", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic MAC: 4+3+2+1 = 10, latency MAC_LAT, busy throughout
    send(OP_MAC, 32'h0102_0304, 32'h0101_0101, data, lat, busy_ok);
    check("mac_basic", data, 32'h0000_000A);
    check("mac_latency", lat, MAC_LAT);
    check("mac_busy", {31'd0, busy_ok}, 32'd1);
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("read_after_mac", data, 32'h0000_000A);
    check("read_latency", lat, 1);

    // offset 128 cancels a=-128 lanes
    send(OP_OFS, 32'd128, 32'd0, data, lat, busy_ok);
    check("set_offset_rsp", data, 32'd0);
    send(OP_MAC, 32'h8080_8080, 32'h0505_0505, data, lat, busy_ok);
    check("mac_offset128", data, 32'h0000_000A);

    // Negative lanes: 4 * (-1 * 2) = -8
    send(OP_OFS, 32'd0, 32'd0, data, lat, busy_ok);
    send(OP_CLR, 32'd0, 32'd0, data, lat, busy_ok);
    check("clr_rsp", data, 32'd0);
    send(OP_MAC, 32'hFFFF_FFFF, 32'h0202_0202, data, lat, busy_ok);
    check("mac_negative", data, 32'hFFFF_FFF8);

    // Response back-pressure: READ held 5 cycles while a CLR is offered
    @(negedge clk);
    cmd_valid = 1'b1;
    function_id = {OP_READ, 3'b000};
    @(posedge clk); #1;
    function_id = {OP_CLR, 3'b000};
    check("stall_first_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_payload", rsp_data, 32'hFFFF_FFF8);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("next_accept_valid", {31'd0, rsp_valid}, 32'd1);
    check("next_accept_clr", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("read_after_clr", data, 32'd0);

    // Crossing int32 max
`ifdef CFU_SIMD_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h8000_0009;
`endif
    send(OP_LOAD, 32'h7FFF_FFFF, 32'd0, data, lat, busy_ok);
    check("load_rsp", data, 32'd0);
    send(OP_MAC, 32'h0102_0304, 32'h0101_0101, data, lat, busy_ok);
    check("mac_overflow", data, exp_sat);
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("read_overflow", data, exp_sat);
    send(OP_RCLR, 32'd0, 32'd0, data, lat, busy_ok);
    check("read_clr_old", data, exp_sat);
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("read_clr_zero", data, 32'd0);

    // Offset -1: 3+2+1+0 = 6
    send(OP_OFS, 32'h0000_01FF, 32'd0, data, lat, busy_ok);
    send(OP_MAC, 32'h0102_0304, 32'h0101_0101, data, lat, busy_ok);
    check("mac_offset_neg", data, 32'd6);

    // Unknown opcode leaves acc and offset intact
    send(OP_LOAD, 32'h1234_5678, 32'd0, data, lat, busy_ok);
    send(7'h7F, 32'd0, 32'd0, data, lat, busy_ok);
    check("unknown_rsp", data, 32'hFFFF_FFFF);
    check("unknown_latency", lat, 1);
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("unknown_acc_kept", data, 32'h1234_5678);
    send(OP_MAC, 32'h0102_0304, 32'h0101_0101, data, lat, busy_ok);
    check("unknown_offset_kept", data, 32'h1234_567E);

    // Reset in the middle of a MAC
    @(negedge clk);
    cmd_valid = 1'b1;
    function_id = {OP_MAC, 3'b000};
    in0 = 32'h0102_0304;
    in1 = 32'h0101_0101;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("exec_busy", {31'd0, cmd_ready}, 32'd0);
    check("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_payload", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(OP_READ, 32'd0, 32'd0, data, lat, busy_ok);
    check("midrst_acc_zero", data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cfu_simd_mac.md
Name: cfu_simd_mac

Overview:
Parametrised successor to the single-function conv1d CFU front-end. It accepts CFU commands over the standard cmd/rsp handshake and decodes funct7 into accumulator operations. Its main operation is a packed SIMD multiply-accumulate with an input offset, as used in quantised conv/FC inner loops. It sits directly behind the CPU CFU port, and its MAC path has a true multi-cycle latency with an explicit busy state.

Parameters:
DATA_W, 8, lane operand width; legal values 4, 8, 16; LANES = 32/DATA_W.
OFFSET_W, 9, signed input-offset width.
ACC_W, 40, signed accumulator width; legal range 32..64.
MAC_LATENCY, 2, cycles from MAC accept to rsp_valid; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  block can accept a command.
cmd_payload_function_id  in  10  [9:3] = funct7 opcode; [2:0] ignored.
cmd_payload_inputs_0  in  32  operand A (packed lanes, or low word).
cmd_payload_inputs_1  in  32  operand B (packed lanes, or high word).
rsp_valid  out  1  response available.
rsp_ready  in  1  CPU takes response.
rsp_payload_outputs_0  out  32  response data.

Behaviour:
- Reset, asserted at any time, including mid-operation:
  - state=IDLE, rsp_valid=0, rsp_payload_outputs_0=0.
  - acc=0, offset=0, pipeline flushed.
- cmd_ready = (state==IDLE). A command is accepted only on cmd_valid && cmd_ready. cmd_valid while busy has no effect.
- States:
  - IDLE -> EXEC when a MAC is accepted.
  - IDLE -> RESP when any other command is accepted.
  - EXEC -> RESP when the latency counter expires.
  - RESP -> IDLE on rsp_ready.
- rsp_valid = (state==RESP). The payload is registered and held stable while rsp_valid=1.
- Latency:
  - Non-MAC: rsp_valid high in the cycle after accept.
  - MAC: rsp_valid high exactly MAC_LATENCY cycles after accept.
- rsp_ready while rsp_valid=0 is ignored. The earliest next accept is the cycle after the rsp handshake.
- funct7 opcodes:
  - 0 CLR_ACC: acc<=0; respond 0.
  - 1 SET_OFFSET: offset<=inputs_0[OFFSET_W-1:0] signed; respond 0.
  - 2 MAC: acc <= acc + sum over i<LANES of (a_i+offset)*b_i.
    - a_i, b_i are signed DATA_W slices, lane 0 at bits [DATA_W-1:0].
    - Lane sum computed at full precision, then sign-extended to ACC_W.
    - acc wraps modulo 2^ACC_W.
    - Respond READ value of the new acc.
  - 3 READ_ACC: respond READ value; acc unchanged.
  - 4 READ_CLR: respond READ value of the old acc; acc<=0.
  - 5 LOAD_ACC: acc <= sign-extend({inputs_1, inputs_0}[ACC_W-1:0]); respond 0.
  - Other values: no state change; respond 0xFFFFFFFF.
- READ value: acc[31:0], unless overridden by the optional feature.

Optional Feature:
CFU_SIMD_SAT_EN
- Defined: the READ value saturates acc to signed 32-bit.
  - acc > 2^31-1 returns 0x7FFFFFFF.
  - acc < -2^31 returns 0x80000000.
- Undefined: the READ value is acc[31:0] (truncation). acc storage is identical in both builds.

Decomposition:
- Package cfu_simd_pkg holds:
  - funct7 opcode localparams/enum.
  - FSM state enum.
  - Unknown-opcode response constant 0xFFFFFFFF.
  - LANES derivation function.
- One sub-module, cfu_simd_dot: LANES-wide offset-multiply-add tree, pipelined to MAC_LATENCY-1 register stages. It is stateless except for the pipeline registers; the top owns the accumulator.

Test Plan:
- Reset mid-MAC (drop reset during EXEC) -> rsp_valid=0, cmd_ready=1 after release; READ_ACC returns 0.
- DATA_W=8, offset 0, MAC inputs_0=0x01020304, inputs_1=0x01010101 -> rsp 0x0000000A exactly MAC_LATENCY cycles after accept; cmd_ready=0 throughout.
- SET_OFFSET 128, MAC inputs_0=0x80808080, inputs_1=0x05050505 -> acc unchanged. Offset 0, MAC inputs_0=0xFFFFFFFF, inputs_1=0x02020202 from acc=0 -> 0xFFFFFFF8.
- rsp_ready held low 5 cycles -> rsp_valid and payload stable, new cmd_valid ignored. After the handshake, the next cmd is accepted one cycle later.
- LOAD_ACC inputs_1=0, inputs_0=0x7FFFFFFF, then MAC +10 (as in test 2):
  - With CFU_SIMD_SAT_EN, READ_ACC -> 0x7FFFFFFF.
  - Without it -> 0x80000009.
  - READ_CLR then READ_ACC -> 0.
- funct7=0x7F -> rsp 0xFFFFFFFF; acc and offset unchanged, verified by a subsequent READ_ACC.
